// File: rtl/coin_credit_unit.sv
// Coin credit unit: accumulates coin credit (max 60 units), vends one of three
// products when credit covers the price, and returns leftover or cancelled
// credit as a train of change pulses, one pulse per 5 units.
module coin_credit_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] coin,
    input  logic [1:0] sel,
    input  logic       sel_valid,
    input  logic       cancel,
    output logic [1:0] vend_code,
    output logic       vend_valid,
    output logic [5:0] credit,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       insufficient,
    output logic       busy
);

    typedef enum logic [2:0] {
        ACCEPT = 3'd0,
        VEND   = 3'd1,
        WAIT   = 3'd2,
        REFUND = 3'd3,
        GAP    = 3'd4
    } state_t;

    localparam logic [5:0] CREDIT_MAX = 6'd60;

    state_t     state_reg;
    logic [5:0] credit_reg;
    logic [1:0] sel_reg;
    logic [1:0] coin_prev_reg;
    logic       coin_reject_reg;
    logic       insufficient_reg;

    logic       coin_event;
    logic [5:0] coin_value;
    logic [5:0] price;
    logic [6:0] credit_sum;

    // Coin edge detection, coin/product value decode and the tentative new credit.
    always_comb begin
        coin_event = (coin != 2'b00) && (coin_prev_reg == 2'b00);
        case (coin)
            2'b01:   coin_value = 6'd5;
            2'b10:   coin_value = 6'd10;
            2'b11:   coin_value = 6'd20;
            default: coin_value = 6'd0;
        endcase
        case (sel)
            2'b01:   price = 6'd5;
            2'b10:   price = 6'd10;
            2'b11:   price = 6'd20;
            default: price = 6'd0;
        endcase
        credit_sum = {1'b0, credit_reg} + {1'b0, coin_value};
    end

    // Control FSM together with credit, latched selection and the pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ACCEPT;
            credit_reg       <= 6'd0;
            sel_reg          <= 2'b00;
            coin_prev_reg    <= 2'b00;
            coin_reject_reg  <= 1'b0;
            insufficient_reg <= 1'b0;
        end else begin
            coin_prev_reg    <= coin;
            coin_reject_reg  <= 1'b0;
            insufficient_reg <= 1'b0;
            // Coins are only credited while idle; anything else bounces back.
            if (coin_event && (state_reg != ACCEPT)) begin
                coin_reject_reg <= 1'b1;
            end
            case (state_reg)
                ACCEPT: begin
                    if (cancel && (credit_reg != 6'd0)) begin
                        state_reg <= REFUND;
                        if (coin_event) coin_reject_reg <= 1'b1;
                    end else if (sel_valid && (sel != 2'b00)) begin
                        if (credit_reg >= price) begin
                            credit_reg <= credit_reg - price;
                            sel_reg    <= sel;
                            state_reg  <= VEND;
                        end else begin
                            insufficient_reg <= 1'b1;
                        end
                        // A selection in the same cycle outranks the coin.
                        if (coin_event) coin_reject_reg <= 1'b1;
                    end else if (coin_event) begin
                        if (credit_sum <= {1'b0, CREDIT_MAX}) begin
                            credit_reg <= credit_sum[5:0];
                        end else begin
                            coin_reject_reg <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    state_reg <= (credit_reg != 6'd0) ? REFUND : ACCEPT;
                end
                REFUND: begin
                    if (credit_reg >= 6'd5) credit_reg <= credit_reg - 6'd5;
                    else                    credit_reg <= 6'd0;
                    state_reg <= GAP;
                end
                GAP: begin
                    state_reg <= (credit_reg != 6'd0) ? REFUND : ACCEPT;
                end
                default: begin
                    state_reg <= ACCEPT;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        vend_valid   = (state_reg == VEND);
        vend_code    = (state_reg == VEND) ? sel_reg : 2'b00;
        change_pulse = (state_reg == REFUND);
        busy         = (state_reg != ACCEPT);
        credit       = credit_reg;
        coin_reject  = coin_reject_reg;
        insufficient = insufficient_reg;
    end

endmodule

// File: doc/coin_credit_unit.md
COIN_CREDIT_UNIT -- requirements
Module: coin_credit_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port coin, input, 2 bits: 00 none, 01 = 5 units, 10 = 10 units, 11 = 20 units.
REQ-004 SHALL have port sel, input, 2 bits: product select; 01 A (price 5), 10 B (price 10), 11 C (price 20), 00 none.
REQ-005 SHALL have port sel_valid, input, 1 bit: sel is qualified on cycles where sel_valid = 1.
REQ-006 SHALL have port cancel, input, 1 bit: refund request.
REQ-007 SHALL have port vend_code, output, 2 bits: product code to the downstream vending stage; 00 when idle.
REQ-008 SHALL have port vend_valid, output, 1 bit: high exactly while vend_code != 00.
REQ-009 SHALL have port credit, output, 6 bits: current credit in units, always a multiple of 5, range 0..60.
REQ-010 SHALL have port change_pulse, output, 1 bit: one pulse per 5 units returned.
REQ-011 SHALL have port coin_reject, output, 1 bit: one-cycle pulse, coin not credited.
REQ-012 SHALL have port insufficient, output, 1 bit: one-cycle pulse, selection refused for lack of credit.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except ACCEPT.

Function
REQ-014 SHALL implement states ACCEPT, VEND, WAIT, REFUND, GAP; all outputs registered or decoded from registered state only.
REQ-015 SHALL detect a coin event at edge N when coin != 00 and the coin sample from edge N-1 was 00; a held code counts once.
REQ-016 In ACCEPT, a coin event SHALL add its value to credit at edge N if the sum is <= 60; otherwise credit is unchanged and coin_reject is 1 for the cycle after edge N.
REQ-017 A coin event in any state other than ACCEPT SHALL be rejected: coin_reject pulse, credit unchanged.
REQ-018 In ACCEPT, priority SHALL be cancel > sel_valid > coin event; a coin event losing priority SHALL be rejected per REQ-016.
REQ-019 In ACCEPT, cancel with credit > 0 SHALL go to REFUND; cancel with credit = 0 SHALL have no effect.
REQ-020 In ACCEPT, sel_valid with sel != 00 and credit >= price SHALL latch sel, subtract the price from credit at edge N, and go to VEND.
REQ-021 In ACCEPT, sel_valid with credit < price SHALL pulse insufficient for one cycle and leave state and credit unchanged; sel_valid with sel = 00 SHALL be ignored.
REQ-022 VEND SHALL last exactly one cycle with vend_code = latched sel and vend_valid = 1, then go to WAIT.
REQ-023 WAIT SHALL last one cycle with vend_code = 00, then go to REFUND if credit > 0, else to ACCEPT; leftover credit is always returned after a vend.
REQ-024 REFUND SHALL drive change_pulse = 1 for one cycle, decrement credit by 5 at its exit edge, and go to GAP.
REQ-025 GAP SHALL drive change_pulse = 0 for one cycle, then go to REFUND if credit > 0, else to ACCEPT.
REQ-026 cancel and sel_valid outside ACCEPT SHALL be ignored and SHALL NOT be queued.
REQ-027 credit SHALL never underflow below 0 or exceed 60.

Reset
REQ-028 reset = 0 SHALL immediately force state ACCEPT, credit 0, latched sel 00, previous coin sample 00, and all outputs 0, including mid-VEND or mid-REFUND.
REQ-029 With coin held non-zero across reset release, the first rising edge after release SHALL count one coin event.

Verification
REQ-030 Reset, then coin = 10 held 3 cycles -> credit = 10 once, no coin_reject.
REQ-031 Credit 20, sel = 10 with sel_valid -> next cycle vend_code = 10 and vend_valid = 1 for 1 cycle; credit 10; WAIT; then change_pulse 1,0,1,0; credit 0; busy low.
REQ-032 Credit 5, sel = 11 with sel_valid -> insufficient = 1 for one cycle; credit 5; vend_valid stays 0.
REQ-033 Three 20-unit coins (credit 60), then 5 -> coin_reject pulse; credit stays 60.
REQ-034 Credit 15, cancel -> three change_pulses separated by gap cycles; a coin inserted during REFUND -> coin_reject, credit unaffected.
REQ-035 reset asserted during REFUND with credit 10 -> change_pulse, busy, and credit are 0 immediately; after release the block is in ACCEPT.
